// File: rtl/display_scheduler_if.sv
// display_scheduler_if
//   Bundles the value-source, control and display-status signals shared
//   between the value producers and display_scheduler.
//   master : producer/control side (drives sources, enables, pause, alert)
//   slave  : display_scheduler side (drives the decoder value and LED status)
interface display_scheduler_if;
  logic [7:0] valor_0;
  logic [7:0] valor_1;
  logic [7:0] valor_2;
  logic [7:0] valor_3;
  logic [3:0] habilita;
  logic       pausa;
  logic       alerta;
  logic [1:0] alerta_idx;
  logic [7:0] valor_out;
  logic [1:0] sel_out;
  logic       blank;
  logic       overflow;
  logic       em_alerta;
  logic       slot_start;

  modport master (
    output valor_0, valor_1, valor_2, valor_3, habilita, pausa, alerta, alerta_idx,
    input  valor_out, sel_out, blank, overflow, em_alerta, slot_start
  );

  modport slave (
    input  valor_0, valor_1, valor_2, valor_3, habilita, pausa, alerta, alerta_idx,
    output valor_out, sel_out, blank, overflow, em_alerta, slot_start
  );
endinterface

// File: rtl/display_scheduler.sv
// display_scheduler
//   Time-shares one two-digit decimal display between four 8-bit sources.
//   Enabled sources are shown round-robin for TICK_DIV clocks each; pausa
//   freezes the current slot; an alerta pulse pre-empts the rotation and
//   holds alerta_idx for ALERT_SLOTS slots before resuming.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : display_scheduler_if.slave
//           in : valor_0..3, habilita, pausa, alerta, alerta_idx
//           out: valor_out (0..99), sel_out, blank, overflow, em_alerta,
//                slot_start
module display_scheduler #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned ALERT_SLOTS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_scheduler_if.slave   bus
);

  localparam int unsigned CW  = $clog2(TICK_DIV);
  localparam int unsigned ACW = $clog2(ALERT_SLOTS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_ALERT = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [ACW-1:0]  r_acnt;
  logic [1:0]      r_resume;
  logic            r_resume_vld;
  logic [1:0]      r_sel;
  logic [7:0]      r_val;
  logic            r_ovf;
  logic            r_slot_start;

  state_t          w_state_nxt;
  logic [1:0]      w_sel_nxt;
  logic            w_load;
  logic            w_cnt_clr;
  logic            w_cnt_inc;
  logic            w_acnt_clr;
  logic            w_acnt_inc;
  logic [1:0]      w_resume_nxt;
  logic            w_resume_vld_nxt;
  logic            w_tick_end;
  logic            w_alert_last;
  logic [7:0]      w_src;
  logic            w_over;
  logic [7:0]      w_val_ld;

  // Next enabled index after s, searching upward with wrap; s itself is the
  // last candidate so a lone enabled source re-selects itself. Walking k
  // downward lets the closest candidate overwrite the result last.
  function automatic logic [1:0] f_next_after(input logic [3:0] hab, input logic [1:0] s);
    logic [1:0] idx;
    f_next_after = s;
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = s + 2'(k);
      if (hab[idx]) f_next_after = idx;
    end
  endfunction

  assign w_tick_end   = (r_cnt == CW'(TICK_DIV - 1));
  assign w_alert_last = (r_acnt == ACW'(ALERT_SLOTS - 1));

  // State / datapath register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_acnt       <= '0;
      r_resume     <= '0;
      r_resume_vld <= 1'b0;
      r_sel        <= '0;
      r_val        <= '0;
      r_ovf        <= 1'b0;
      r_slot_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_resume     <= w_resume_nxt;
      r_resume_vld <= w_resume_vld_nxt;
      r_sel        <= w_sel_nxt;
      r_slot_start <= w_load;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
      if (w_acnt_clr)      r_acnt <= '0;
      else if (w_acnt_inc) r_acnt <= r_acnt + ACW'(1);
      if (w_load) begin
        r_val <= w_val_ld;
        r_ovf <= w_over;
      end
    end
  end

  // Next-state logic; alerta is checked first so it beats every other event.
  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_load           = 1'b0;
    w_cnt_clr        = 1'b0;
    w_cnt_inc        = 1'b0;
    w_acnt_clr       = 1'b0;
    w_acnt_inc       = 1'b0;
    w_resume_nxt     = r_resume;
    w_resume_vld_nxt = r_resume_vld;
    if (bus.alerta) begin
      w_state_nxt = S_ALERT;
      w_sel_nxt   = bus.alerta_idx;
      w_load      = 1'b1;
      w_cnt_clr   = 1'b1;
      w_acnt_clr  = 1'b1;
      // A restart during ALERT keeps the originally interrupted index.
      if (r_state != S_ALERT) begin
        w_resume_nxt     = r_sel;
        w_resume_vld_nxt = (r_state == S_SHOW);
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|bus.habilita) begin
            w_state_nxt = S_SHOW;
            w_sel_nxt   = f_next_after(bus.habilita, 2'd3);
            w_load      = 1'b1;
            w_cnt_clr   = 1'b1;
          end
        end
        S_SHOW: begin
          if (bus.habilita == 4'd0) begin
            w_state_nxt = S_IDLE;
          end else if (!bus.habilita[r_sel] || (w_tick_end && !bus.pausa)) begin
            w_sel_nxt = f_next_after(bus.habilita, r_sel);
            w_load    = 1'b1;
            w_cnt_clr = 1'b1;
          end else if (!bus.pausa) begin
            w_cnt_inc = 1'b1;
          end
        end
        S_ALERT: begin
          if (!w_tick_end) begin
            w_cnt_inc = 1'b1;
          end else if (!w_alert_last) begin
            w_acnt_inc = 1'b1;
            w_load     = 1'b1;
            w_cnt_clr  = 1'b1;
          end else begin
            w_cnt_clr = 1'b1;
            if (r_resume_vld && bus.habilita[r_resume]) begin
              w_state_nxt = S_SHOW;
              w_sel_nxt   = r_resume;
              w_load      = 1'b1;
            end else if (|bus.habilita) begin
              w_state_nxt = S_SHOW;
              w_sel_nxt   = r_resume_vld ? f_next_after(bus.habilita, r_resume)
                                         : f_next_after(bus.habilita, 2'd3);
              w_load      = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Source value for the slot being entered, clamped to two decimal digits.
  always_comb begin
    w_src = bus.valor_0;
    unique case (w_sel_nxt)
      2'd0: w_src = bus.valor_0;
      2'd1: w_src = bus.valor_1;
      2'd2: w_src = bus.valor_2;
      2'd3: w_src = bus.valor_3;
      default: w_src = bus.valor_0;
    endcase
  end

  assign w_over   = (w_src > 8'd99);
  assign w_val_ld = w_over ? 8'd99 : w_src;

  // Outputs
  always_comb begin
    bus.valor_out  = r_val;
    bus.sel_out    = r_sel;
    bus.blank      = (r_state == S_IDLE);
    bus.overflow   = r_ovf;
    bus.em_alerta  = (r_state == S_ALERT);
    bus.slot_start = r_slot_start;
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler (TICK_DIV=4, ALERT_SLOTS=2).
module tb_display_scheduler;

  localparam int TD = 4;
  localparam int AS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  display_scheduler_if ifc();

  display_scheduler #(.TICK_DIV(TD), .ALERT_SLOTS(AS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=show 2=alert; left = show cycles remaining in slot;
  // aleft = alert cycles remaining overall; resume = -1 for none.
  typedef struct packed {
    int mode;
    int sel;
    int val;
    int ovf;
    int ss;
    int left;
    int aleft;
    int resume;
  } m_t;

  localparam m_t M_RST = '{mode: 0, sel: 0, val: 0, ovf: 0, ss: 0, left: 0, aleft: 0, resume: -1};

  function automatic int nxt(int hab, int s);
    for (int k = 1; k <= 4; k++) begin
      if (hab[(s + k) % 4]) return (s + k) % 4;
    end
    return -1;
  endfunction

  function automatic m_t latch(m_t n, int idx, int v);
    n.sel = idx;
    n.val = (v > 99) ? 99 : v;
    n.ovf = (v > 99) ? 1 : 0;
    n.ss  = 1;
    return n;
  endfunction

  function automatic m_t step(m_t m, int v0, int v1, int v2, int v3,
                              int hab, int pa, int al, int aidx);
    m_t n;
    int v[4];
    int j;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    n = m;
    n.ss = 0;
    if (al != 0) begin
      if (m.mode != 2) n.resume = (m.mode == 1) ? m.sel : -1;
      n.mode  = 2;
      n       = latch(n, aidx, v[aidx]);
      n.aleft = AS * TD;
    end else if (m.mode == 0) begin
      if (hab != 0) begin
        j = nxt(hab, 3);
        n.mode = 1;
        n = latch(n, j, v[j]);
        n.left = TD;
      end
    end else if (m.mode == 1) begin
      if (hab == 0) begin
        n.mode = 0;
      end else if (!hab[m.sel] || (pa == 0 && m.left == 1)) begin
        j = nxt(hab, m.sel);
        n = latch(n, j, v[j]);
        n.left = TD;
      end else if (pa == 0) begin
        n.left = m.left - 1;
      end
    end else begin
      n.aleft = m.aleft - 1;
      if (n.aleft == 0) begin
        if (m.resume >= 0 && hab[m.resume]) j = m.resume;
        else if (hab != 0) j = (m.resume >= 0) ? nxt(hab, m.resume) : nxt(hab, 3);
        else j = -1;
        if (j < 0) n.mode = 0;
        else begin
          n.mode = 1;
          n = latch(n, j, v[j]);
          n.left = TD;
        end
      end else if (n.aleft % TD == 0) begin
        n = latch(n, m.sel, v[m.sel]);
      end
    end
    return n;
  endfunction

  m_t m = M_RST;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RST;
    else m <= step(m, int'(ifc.valor_0), int'(ifc.valor_1), int'(ifc.valor_2), int'(ifc.valor_3),
                   int'(ifc.habilita), int'(ifc.pausa), int'(ifc.alerta), int'(ifc.alerta_idx));
  end

  always @(negedge clk) begin
    check("valor_out",  32'(ifc.valor_out),  32'(m.val));
    check("sel_out",    32'(ifc.sel_out),    32'(m.sel));
    check("blank",      32'(ifc.blank),      32'(m.mode == 0));
    check("overflow",   32'(ifc.overflow),   32'(m.ovf));
    check("em_alerta",  32'(ifc.em_alerta),  32'(m.mode == 2));
    check("slot_start", 32'(ifc.slot_start), 32'(m.ss));
  end

  task automatic drv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_blank"}, 32'(ifc.blank), 32'd1);
    check({tag, "_val"},   32'(ifc.valor_out), 32'd0);
    check({tag, "_sel"},   32'(ifc.sel_out), 32'd0);
    check({tag, "_ovf"},   32'(ifc.overflow), 32'd0);
    check({tag, "_em"},    32'(ifc.em_alerta), 32'd0);
    check({tag, "_ss"},    32'(ifc.slot_start), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.valor_0 = 8'd0; ifc.valor_1 = 8'd0; ifc.valor_2 = 8'd0; ifc.valor_3 = 8'd0;
    ifc.habilita = 4'd0; ifc.pausa = 1'b0; ifc.alerta = 1'b0; ifc.alerta_idx = 2'd0;
    #1 rst_n = 1'b0;
    drv(2);
    @(negedge clk);
    chk_reset_vals("rst");

    // Rotation over sources 0 and 2
    rst_n = 1'b1;
    ifc.valor_0 = 8'd12; ifc.valor_1 = 8'd5; ifc.valor_2 = 8'd47; ifc.valor_3 = 8'd88;
    ifc.habilita = 4'b0101;
    drv(1); @(negedge clk);
    check("lit_first_sel", 32'(ifc.sel_out), 32'd0);
    check("lit_first_val", 32'(ifc.valor_out), 32'd12);
    check("lit_first_ss", 32'(ifc.slot_start), 32'd1);
    check("lit_first_blank", 32'(ifc.blank), 32'd0);
    drv(4); @(negedge clk);
    check("lit_rot_sel", 32'(ifc.sel_out), 32'd2);
    check("lit_rot_val", 32'(ifc.valor_out), 32'd47);

    // Clamp and mid-slot source change
    ifc.valor_0 = 8'd150;
    drv(4); @(negedge clk);
    check("lit_clamp_val", 32'(ifc.valor_out), 32'd99);
    check("lit_clamp_ovf", 32'(ifc.overflow), 32'd1);
    ifc.valor_0 = 8'd30;
    drv(1); @(negedge clk);
    check("lit_hold_val", 32'(ifc.valor_out), 32'd99);
    drv(3); @(negedge clk);
    check("lit_ovf_clr", 32'(ifc.overflow), 32'd0);
    check("lit_ovf_sel", 32'(ifc.sel_out), 32'd2);

    // Pause for 10 clocks mid-slot
    drv(1); ifc.pausa = 1'b1;
    drv(10); ifc.pausa = 1'b0;
    drv(2); @(negedge clk);
    check("lit_pause_sel", 32'(ifc.sel_out), 32'd2);
    check("lit_pause_ss", 32'(ifc.slot_start), 32'd0);
    drv(1); @(negedge clk);
    check("lit_pause_adv_sel", 32'(ifc.sel_out), 32'd0);
    check("lit_pause_adv_val", 32'(ifc.valor_out), 32'd30);

    // Alert on disabled source 3 while showing source 2
    drv(4); drv(1);
    ifc.alerta = 1'b1; ifc.alerta_idx = 2'd3;
    drv(1); ifc.alerta = 1'b0;
    @(negedge clk);
    check("lit_alert_em", 32'(ifc.em_alerta), 32'd1);
    check("lit_alert_sel", 32'(ifc.sel_out), 32'd3);
    check("lit_alert_val", 32'(ifc.valor_out), 32'd88);
    drv(4); @(negedge clk);
    check("lit_alert_ss2", 32'(ifc.slot_start), 32'd1);
    drv(4); @(negedge clk);
    check("lit_resume_em", 32'(ifc.em_alerta), 32'd0);
    check("lit_resume_sel", 32'(ifc.sel_out), 32'd2);

    // All enables removed mid-slot, then re-enable source 1
    ifc.habilita = 4'b0100;
    drv(1); ifc.habilita = 4'b0000;
    drv(1); @(negedge clk);
    check("lit_idle_blank", 32'(ifc.blank), 32'd1);
    check("lit_idle_val", 32'(ifc.valor_out), 32'd47);
    ifc.habilita = 4'b0010;
    drv(1); @(negedge clk);
    check("lit_reen_sel", 32'(ifc.sel_out), 32'd1);
    check("lit_reen_val", 32'(ifc.valor_out), 32'd5);
    drv(4); @(negedge clk);
    check("lit_self_ss", 32'(ifc.slot_start), 32'd1);

    // Current source disabled mid-slot: advance to next enabled (3)
    drv(1); ifc.habilita = 4'b1001;
    drv(1); @(negedge clk);
    check("lit_drop_sel", 32'(ifc.sel_out), 32'd3);

    // Alert restarted during alert keeps original resume index
    drv(1); ifc.alerta = 1'b1; ifc.alerta_idx = 2'd1;
    drv(1); ifc.alerta = 1'b0;
    drv(2); ifc.alerta = 1'b1; ifc.alerta_idx = 2'd0;
    drv(1); ifc.alerta = 1'b0;
    @(negedge clk);
    check("lit_restart_sel", 32'(ifc.sel_out), 32'd0);
    drv(8); @(negedge clk);
    check("lit_restart_resume", 32'(ifc.sel_out), 32'd3);

    // Alert from IDLE with nothing enabled returns to IDLE
    ifc.habilita = 4'b0000;
    drv(1); ifc.alerta = 1'b1; ifc.alerta_idx = 2'd2;
    drv(1); ifc.alerta = 1'b0;
    drv(8); @(negedge clk);
    check("lit_alert_idle", 32'(ifc.blank), 32'd1);

    // Resume index disabled during alert: next enabled after it
    ifc.habilita = 4'b0011;
    drv(1); drv(1);
    ifc.alerta = 1'b1; ifc.alerta_idx = 2'd2;
    drv(1); ifc.alerta = 1'b0; ifc.habilita = 4'b0110;
    drv(8); @(negedge clk);
    check("lit_resume_next", 32'(ifc.sel_out), 32'd1);

    // Asynchronous reset mid-alert
    ifc.alerta = 1'b1; ifc.alerta_idx = 2'd2;
    drv(1); ifc.alerta = 1'b0;
    drv(2);
    #2 rst_n = 1'b0; ifc.habilita = 4'b0000;
    #1 chk_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    drv(2); @(negedge clk);
    check("lit_post_rst_blank", 32'(ifc.blank), 32'd1);
    check("lit_post_rst_em", 32'(ifc.em_alerta), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Shares one two-digit decimal display path (8-bit value in, units/tens 7-seg out) between four 8-bit value sources.
- Rotates round-robin through the enabled sources, showing each for a fixed number of clocks.
- Supports a pause, and a priority alert that pre-empts the rotation.
- Sits between the system's value producers and the display decoder. It drives the decoder's 8-bit input plus status for the user-facing LEDs.

Parameters:
- TICK_DIV, 50000000: clocks per display slot (1 s at 50 MHz). Must be ≥2. Counter width is $clog2(TICK_DIV).
- ALERT_SLOTS, 3: number of consecutive slots an alert source is held. Must be ≥1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valor_0, valor_1, valor_2, valor_3  input  8 each  source values, unsigned
- habilita  input  4  per-source enable mask; bit i enables valor_i for rotation
- pausa  input  1  level; freezes the current slot in SHOW
- alerta  input  1  single-cycle pulse requesting a priority display
- alerta_idx  input  2  source shown on alert; sampled when alerta=1
- valor_out  output  8  value to the display decoder, always 0..99
- sel_out  output  2  index of the source currently shown
- blank  output  1  1 = display off (decoder input is don't-care)
- overflow  output  1  1 = the latched source value was >99 and has been clamped
- em_alerta  output  1  1 while in the ALERT state
- slot_start  output  1  one-cycle pulse on the first cycle of every new slot

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - state=IDLE, sel_out=0, valor_out=0
  - blank=1, overflow=0, em_alerta=0, slot_start=0
  - slot counter=0, alert slot counter=0, resume index=0
- State IDLE:
  - blank=1.
  - If habilita≠0, the next edge enters SHOW with sel_out = lowest-numbered enabled source.
  - alerta=1 has priority over habilita.
- State SHOW:
  - Slot counter increments each clock unless pausa=1 (then it holds).
  - At count TICK_DIV-1 (and pausa=0), the next edge starts a new slot on the next enabled index after sel_out, searching upward with wrap 3→0.
  - A single enabled source re-enters itself: value re-latched, slot_start pulses.
- Enable removed mid-slot:
  - If habilita[sel_out] drops to 0 while in SHOW, the slot is abandoned: the next edge advances as if the slot had ended.
  - If habilita=0 entirely, the next edge goes to IDLE.
- Slot entry (SHOW or ALERT):
  - Counter clears.
  - The selected valor_i is latched into valor_out once; source changes during the slot are ignored.
  - Values >99 are clamped to 99 and set overflow=1; otherwise overflow=0.
  - slot_start=1 for exactly that first cycle.
  - blank=0.
- Latency: outputs change on the edge after the deciding condition, i.e. 1 clock.
- Alert:
  - alerta=1 in any state enters ALERT on the next edge.
  - sel_out=alerta_idx, regardless of habilita. em_alerta=1.
  - Resume index is saved as the interrupted sel_out, or "none" if coming from IDLE.
- ALERT state:
  - Runs ALERT_SLOTS × TICK_DIV clocks. pausa is ignored.
  - The value is re-latched (with slot_start) at each of the ALERT_SLOTS slot boundaries.
- Alert during ALERT:
  - Restarts ALERT with the new index and a full slot count.
  - The original resume index is kept.
- ALERT exit:
  - On expiry, em_alerta=0.
  - Return to SHOW starting a fresh slot on the resume index if it is still enabled.
  - Else go to the next enabled index after it.
  - Else, if habilita=0 or there is no resume index and no enable, go to IDLE.
- Simultaneous events:
  - alerta beats slot-end and enable-drop in the same cycle.
  - Slot-end with pausa=1 does not advance.
  - Asynchronous reset mid-slot or mid-alert returns immediately to reset values; no state is preserved.

Test Plan (TICK_DIV=4, ALERT_SLOTS=2):
- Reset, then habilita=4'b0101, valor_0=12, valor_2=47 → SHOW 1 clock after enable.
  - sel_out sequence 0,2,0,2 with slot_start pulses every 4 clocks.
  - valor_out 12/47, blank=0.
- Source 0 slot with valor_0=150 → valor_out=99, overflow=1. Next slot with valor_2=47 → overflow=0.
  - Changing valor_0 mid-slot leaves valor_out unchanged.
- pausa=1 for 10 clocks mid-slot → sel_out and valor_out frozen, no slot_start. Slot completes its remaining counts after pausa=0.
- alerta pulse with alerta_idx=3 (habilita[3]=0) while showing source 2 →
  - em_alerta=1 and sel_out=3 for 8 clocks, with slot_start at clocks 0 and 4.
  - Then resumes at sel_out=2 with a full slot.
- habilita goes 4'b0100→0 mid-slot → next edge IDLE: blank=1, valor_out holds last value.
  - Re-enable habilita=4'b0010 → SHOW with sel_out=1.
- rst_n asserted low asynchronously during ALERT (between edges) → all outputs at reset values immediately. Release → IDLE.
